tt_pg_seq: RTL and testbench

Sequencer that drives the `ctrl` inputs of one user tile's bank of 1v8 power-gate switch segments. Power-up is staggered segment by segment to limit inrush current, followed by a settle wait. The sequencer then releases output isolation and finally the tile reset. Power-down runs the reverse sequence. It sits in the multiplexer control logic between the tile-enable request and the power-gate cells.

---
 rtl/tt_pg_seq.sv | 144 ++++++++++++++
 tb/tb_tt_pg_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tt_pg_seq.sv
// rtl/tt_pg_seq.sv - staggered power-gate sequencer for one user tile
module tt_pg_seq #(
    parameter int N_SEG      = 4,
    parameter int STEP_CYC   = 16,
    parameter int SETTLE_CYC = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_on,
    output logic [N_SEG-1:0] pg_ctrl,
    output logic             iso,
    output logic             usr_rst_n,
    output logic             pwr_good,
    output logic             busy,
    output logic [2:0]       state
);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_UP      = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_ISO_REL = 3'd3;
    localparam logic [2:0] S_ON      = 3'd4;
    localparam logic [2:0] S_PD_ISO  = 3'd5;
    localparam logic [2:0] S_DOWN    = 3'd6;

    localparam logic [CNT_W-1:0] STEP_LD   = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    // ISO_REL and PD_ISO each hold for two cycles: load 1, leave on 0
    localparam logic [CNT_W-1:0] HOLD2_LD  = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [N_SEG-1:0] pg_q, pg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             iso_q, iso_d;
    logic             usr_q, usr_d;
    logic             good_q, good_d;
    logic             busy_q, busy_d;

    logic             cnt_zero;
    logic             top_on;
    logic [N_SEG-1:0] pg_up;
    logic [N_SEG-1:0] pg_dn;

    assign cnt_zero = (cnt_q == '0);
    assign top_on   = pg_q[N_SEG-1];
    assign pg_up    = (pg_q << 1) | N_SEG'(1);
    assign pg_dn    = pg_q >> 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            pg_q    <= '0;
            cnt_q   <= '0;
            iso_q   <= 1'b1;
            usr_q   <= 1'b0;
            good_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pg_q    <= pg_d;
            cnt_q   <= cnt_d;
            iso_q   <= iso_d;
            usr_q   <= usr_d;
            good_q  <= good_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF:     if (req_on) state_d = S_UP;
            S_UP: begin
                if (!req_on)               state_d = S_DOWN;
                else if (cnt_zero && top_on) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (!req_on)       state_d = S_DOWN;
                else if (cnt_zero) state_d = S_ISO_REL;
            end
            S_ISO_REL: begin
                if (!req_on)       state_d = S_PD_ISO;
                else if (cnt_zero) state_d = S_ON;
            end
            S_ON:      if (!req_on) state_d = S_PD_ISO;
            S_PD_ISO:  if (cnt_zero) state_d = S_DOWN;
            S_DOWN:    if (cnt_zero && (pg_dn == '0)) state_d = S_OFF;
            default:   state_d = S_DOWN;
        endcase
    end

    // Isolation, tile reset and status flags decode purely from the next state
    always_comb begin
        pg_d   = pg_q;
        cnt_d  = cnt_zero ? cnt_q : cnt_q - 1'b1;
        case (state_q)
            S_OFF: begin
                pg_d  = '0;
                cnt_d = '0;
                if (state_d == S_UP) begin
                    pg_d  = N_SEG'(1);
                    cnt_d = STEP_LD;
                end
            end
            S_UP: begin
                if (state_d == S_DOWN) begin
                    cnt_d = STEP_LD;
                end else if (state_d == S_SETTLE) begin
                    cnt_d = SETTLE_LD;
                end else if (cnt_zero) begin
                    pg_d  = pg_up;
                    cnt_d = STEP_LD;
                end
            end
            S_SETTLE: begin
                if (state_d == S_DOWN)         cnt_d = STEP_LD;
                else if (state_d == S_ISO_REL) cnt_d = HOLD2_LD;
            end
            S_ISO_REL: if (state_d == S_PD_ISO) cnt_d = HOLD2_LD;
            S_ON:      if (state_d == S_PD_ISO) cnt_d = HOLD2_LD;
            S_PD_ISO:  if (state_d == S_DOWN)   cnt_d = STEP_LD;
            S_DOWN: begin
                if (cnt_zero) begin
                    pg_d  = pg_dn;
                    cnt_d = (state_d == S_OFF) ? '0 : STEP_LD;
                end
            end
            default:   cnt_d = STEP_LD;
        endcase
        iso_d  = !((state_d == S_ISO_REL) || (state_d == S_ON) || (state_d == S_PD_ISO));
        usr_d  = (state_d == S_ON);
        good_d = (state_d == S_ON);
        busy_d = !((state_d == S_OFF) || (state_d == S_ON));
    end

    assign pg_ctrl   = pg_q;
    assign iso       = iso_q;
    assign usr_rst_n = usr_q;
    assign pwr_good  = good_q;
    assign busy      = busy_q;
    assign state     = state_q;

endmodule

// File: tb/tb_tt_pg_seq.sv
// tb/tb_tt_pg_seq.sv - directed vectors for tt_pg_seq (default and 1/1/1 parameter sets)
module tb_tt_pg_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, req_on;
    logic [3:0] pg;
    logic       iso, usr, good, busy;
    logic [2:0] st;

    logic       rst2_n, req2;
    logic [0:0] pg2;
    logic       iso2, usr2, good2, busy2;
    logic [2:0] st2;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    tt_pg_seq #(.N_SEG(4), .STEP_CYC(16), .SETTLE_CYC(64), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_on(req_on), .pg_ctrl(pg), .iso(iso),
        .usr_rst_n(usr), .pwr_good(good), .busy(busy), .state(st)
    );

    tt_pg_seq #(.N_SEG(1), .STEP_CYC(1), .SETTLE_CYC(1), .CNT_W(8)) u_edge (
        .clk(clk), .rst_n(rst2_n), .req_on(req2), .pg_ctrl(pg2), .iso(iso2),
        .usr_rst_n(usr2), .pwr_good(good2), .busy(busy2), .state(st2)
    );

    typedef struct {
        int         k;
        logic       req;
        logic [3:0] pg;
        logic       iso;
        logic       usr;
        logic       good;
        logic       busy;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int k, input logic req, input logic [3:0] p,
                                input logic i, input logic u, input logic g,
                                input logic b, input logic [2:0] s);
        vec_t v;
        v.k = k; v.req = req; v.pg = p; v.iso = i; v.usr = u; v.good = g; v.busy = b; v.st = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [10:0] main_pk();
        return {pg, iso, usr, good, busy, st};
    endfunction

    function automatic logic [7:0] edge_pk();
        return {pg2, iso2, usr2, good2, busy2, st2};
    endfunction

    // Ordering invariants on both instances every cycle once out of power-on reset
    always @(negedge clk) begin
        if (mon_en) begin
            chk("inv_main", {(!iso && pg != 4'hF), (usr && iso), (good != (st == 3'd4)),
                             (busy != !((st == 3'd0) || (st == 3'd4))), (st > 3'd6)}, 0);
            chk("inv_edge", {(!iso2 && pg2 != 1'b1), (usr2 && iso2), (good2 != (st2 == 3'd4)),
                             (busy2 != !((st2 == 3'd0) || (st2 == 3'd4))), (st2 > 3'd6)}, 0);
        end
    end

    initial begin
        int k;
        logic [3:0] epg;
        logic [2:0] est;
        logic [7:0] eexp [5];

        // k counts edges since req_on last changed; k=1 is the sampling edge's result
        tbl.push_back(mk(1,   1'b1, 4'h1, 1, 0, 0, 1, 3'd1));
        tbl.push_back(mk(16,  1'b1, 4'h1, 1, 0, 0, 1, 3'd1));
        tbl.push_back(mk(17,  1'b1, 4'h3, 1, 0, 0, 1, 3'd1));
        tbl.push_back(mk(33,  1'b1, 4'h7, 1, 0, 0, 1, 3'd1));
        tbl.push_back(mk(49,  1'b1, 4'hF, 1, 0, 0, 1, 3'd1));
        tbl.push_back(mk(64,  1'b1, 4'hF, 1, 0, 0, 1, 3'd1));
        tbl.push_back(mk(65,  1'b1, 4'hF, 1, 0, 0, 1, 3'd2));
        tbl.push_back(mk(128, 1'b1, 4'hF, 1, 0, 0, 1, 3'd2));
        tbl.push_back(mk(129, 1'b1, 4'hF, 0, 0, 0, 1, 3'd3));
        tbl.push_back(mk(130, 1'b1, 4'hF, 0, 0, 0, 1, 3'd3));
        tbl.push_back(mk(131, 1'b1, 4'hF, 0, 1, 1, 0, 3'd4));
        tbl.push_back(mk(140, 1'b1, 4'hF, 0, 1, 1, 0, 3'd4));
        tbl.push_back(mk(1,   1'b0, 4'hF, 0, 0, 0, 1, 3'd5));
        tbl.push_back(mk(2,   1'b0, 4'hF, 0, 0, 0, 1, 3'd5));
        tbl.push_back(mk(3,   1'b0, 4'hF, 1, 0, 0, 1, 3'd6));
        tbl.push_back(mk(18,  1'b0, 4'hF, 1, 0, 0, 1, 3'd6));
        tbl.push_back(mk(19,  1'b0, 4'h7, 1, 0, 0, 1, 3'd6));
        tbl.push_back(mk(35,  1'b0, 4'h3, 1, 0, 0, 1, 3'd6));
        tbl.push_back(mk(51,  1'b0, 4'h1, 1, 0, 0, 1, 3'd6));
        tbl.push_back(mk(66,  1'b0, 4'h1, 1, 0, 0, 1, 3'd6));
        tbl.push_back(mk(67,  1'b0, 4'h0, 1, 0, 0, 0, 3'd0));

        rst_n = 1'b0; req_on = 1'b1;
        rst2_n = 1'b0; req2 = 1'b0;
        adv(3);
        chk("reset_main", main_pk(), {4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
        chk("reset_edge", edge_pk(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
        mon_en = 1'b1;
        rst_n  = 1'b1;

        k = 0;
        foreach (tbl[i]) begin
            if (tbl[i].req !== req_on) begin
                req_on = tbl[i].req;
                k = 0;
            end
            while (k < tbl[i].k) begin
                @(posedge clk);
                k++;
            end
            @(negedge clk);
            chk($sformatf("vec%0d_k%0d", i, tbl[i].k), main_pk(),
                {tbl[i].pg, tbl[i].iso, tbl[i].usr, tbl[i].good, tbl[i].busy, tbl[i].st});
        end

        // Abort while pg_ctrl = 0011 in UP
        req_on = 1'b1;
        adv(17);
        chk("abort_pre", {pg, st}, {4'h3, 3'd1});
        req_on = 1'b0;
        for (int j = 1; j <= 33; j++) begin
            adv(1);
            epg = (j < 17) ? 4'h3 : (j < 33) ? 4'h1 : 4'h0;
            est = (j < 33) ? 3'd6 : 3'd0;
            chk($sformatf("abort_j%0d", j), {pg, iso, usr, st}, {epg, 1'b1, 1'b0, est});
        end

        // req_on returns high mid-DOWN: power-down still completes, then restarts
        req_on = 1'b1;
        adv(17);
        chk("toggle_pre", {pg, st}, {4'h3, 3'd1});
        req_on = 1'b0;
        adv(5);
        req_on = 1'b1;
        for (int j = 6; j <= 34; j++) begin
            adv(1);
            epg = (j < 17) ? 4'h3 : (j < 33) ? 4'h1 : (j == 33) ? 4'h0 : 4'h1;
            est = (j < 33) ? 3'd6 : (j == 33) ? 3'd0 : 3'd1;
            chk($sformatf("toggle_j%0d", j), {pg, st}, {epg, est});
        end

        // Hard reset from SETTLE
        adv(64);
        chk("settle_reached", {pg, iso, st}, {4'hF, 1'b1, 3'd2});
        adv(10);
        rst_n = 1'b0;
        adv(1);
        chk("rst_in_settle", main_pk(), {4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
        rst_n  = 1'b1;
        req_on = 1'b0;
        adv(3);
        chk("off_after_rst", main_pk(), {4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});

        // 1-segment, 1-cycle step/settle instance
        eexp[0] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        eexp[1] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2};
        eexp[2] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
        eexp[3] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
        eexp[4] = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4};
        rst2_n = 1'b1;
        req2   = 1'b1;
        for (int j = 0; j < 5; j++) begin
            adv(1);
            chk($sformatf("edge_T%0d", j + 1), edge_pk(), eexp[j]);
        end
        for (int j = 0; j < 400; j++) begin
            req2 = 1'($urandom_range(0, 1));
            adv(1);
        end
        req2 = 1'b0;
        adv(20);
        chk("edge_off", {pg2, st2}, {1'b0, 3'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
